// File: rtl/mac_arbiter_pkg.sv
// Shared definitions for the two-requester accumulate arbiter: FSM state
// encoding and default datapath widths.
package mac_arbiter_pkg;

    localparam int K_DEF = 8;
    localparam int M_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mac_arbiter_acc_core.sv
// Accumulate datapath: captured addend, k-bit wrapping adder with sticky
// carry flag, Result register and m-bit repeat down-counter.
module acc_core
    import mac_arbiter_pkg::*;
#(
    parameter int k = K_DEF,
    parameter int m = M_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [k-1:0] x_in,
    input  logic [m-1:0] y_in,
    output logic [k-1:0] result,
    output logic         ovf,
    output logic         last
);

    logic [k-1:0] x_reg;
    logic [m-1:0] count;
    logic [k:0]   sum;

    assign sum  = {1'b0, result} + {1'b0, x_reg};
    assign last = (count == m'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg  <= '0;
            count  <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (load) begin
            x_reg  <= x_in;
            count  <= y_in;
            result <= '0;
            ovf    <= 1'b0;
        end else if (en) begin
            result <= sum[k-1:0];
            ovf    <= ovf | sum[k];
            count  <= count - m'(1);
        end
    end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter between two requesters sharing one repeated-add
// (X*Y mod 2^k) datapath.
//
// state | meaning
// IDLE  | no grant; arbitrate when any req is high
// LOAD  | winner granted; capture X/Y, clear Result/ovf, move pointer
// RUN   | add X once per cycle until the repeat count expires
// DONE  | one-cycle done pulse, grant still held; back to IDLE
module mac_arbiter
    import mac_arbiter_pkg::*;
#(
    parameter int k = K_DEF,
    parameter int m = M_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [k-1:0] X0,
    input  logic [m-1:0] Y0,
    input  logic         req1,
    input  logic [k-1:0] X1,
    input  logic [m-1:0] Y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [k-1:0] Result
);

    state_t       state;
    logic         prio;      // 1: requester 1 wins a tie
    logic         pick0;
    logic         last;
    logic [k-1:0] sel_x;
    logic [m-1:0] sel_y;

    assign pick0 = req0 & (~req1 | ~prio);
    assign sel_x = gnt1 ? X1 : X0;
    assign sel_y = gnt1 ? Y1 : Y0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            prio  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        state <= ST_LOAD;
                        gnt0  <= pick0;
                        gnt1  <= ~pick0;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    prio <= gnt0;
                    if (sel_y == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    acc_core #(.k(k), .m(m)) u_acc_core (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_LOAD),
        .en     (state == ST_RUN),
        .x_in   (sel_x),
        .y_in   (sel_y),
        .result (Result),
        .ovf    (ovf),
        .last   (last)
    );

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed self-checking bench for mac_arbiter with hand-computed results.
module tb_mac_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] X0, X1;
    logic [3:0] Y0, Y1;
    logic       gnt0, gnt1, busy, done, ovf;
    logic [7:0] Result;

    int checks   = 0;
    int failures = 0;

    mac_arbiter #(.k(8), .m(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .X0     (X0),
        .Y0     (Y0),
        .req1   (req1),
        .X1     (X1),
        .Y1     (Y1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cycles from the current cycle until done is seen; -1 if it never comes
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 40);
        if (!done) n = -1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        step();
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        req0 = 0; req1 = 0; X0 = 0; X1 = 0; Y0 = 0; Y1 = 0;
        #2;
        checks++;
        if ({gnt0, gnt1, busy, done, ovf, Result} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {gnt0, gnt1, busy, done, ovf, Result});
        end
        step(); step();
        reset = 1'b1;
        step();
        n = 0;
        checks++;
        if (gnt0 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset gnt0=%b busy=%b want 0 0", gnt0, busy);
        end
    endtask

    task automatic test_basic();
        int n;
        req0 = 1; X0 = 8'd5; Y0 = 4'd3;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_load gnt0=%b gnt1=%b busy=%b want 1 0 1", gnt0, gnt1, busy);
        end
        req0 = 0;
        step();
        X0 = 8'hFF; Y0 = 4'hF;   // changes after LOAD must be ignored
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL basic_done_latency got=%0d want=4", n);
        end
        checks++;
        if (Result !== 8'd15 || ovf !== 1'b0 || gnt0 !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_result Result=%0d ovf=%b gnt0=%b busy=%b want 15 0 1 0", Result, ovf, gnt0, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || gnt0 !== 1'b0 || Result !== 8'd15) begin
            failures++;
            $display("FAIL basic_after_done done=%b gnt0=%b Result=%0d want 0 0 15", done, gnt0, Result);
        end
    endtask

    task automatic test_round_robin();
        int n;
        pulse_reset();
        req0 = 1; X0 = 8'd2; Y0 = 4'd2;
        req1 = 1; X1 = 8'd3; Y1 = 4'd1;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL rr_first_grant gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        step();
        req0 = 0;
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        checks++;
        if (n !== 3 || Result !== 8'd4) begin
            failures++;
            $display("FAIL rr_first_op n=%0d Result=%0d want 3 4", n, Result);
        end
        step();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle_gap gnt0=%b gnt1=%b want 0 0", gnt0, gnt1);
        end
        step();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL rr_second_grant gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
        end
        step();
        req1 = 0;
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        checks++;
        if (n !== 2 || Result !== 8'd3 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL rr_second_op n=%0d Result=%0d ovf=%b want 2 3 0", n, Result, ovf);
        end
        step();
    endtask

    task automatic test_overflow();
        int n;
        req0 = 1; X0 = 8'd200; Y0 = 4'd2;
        step();
        step();
        req0 = 0;
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        checks++;
        if (n !== 3 || Result !== 8'd144 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_op n=%0d Result=%0d ovf=%b want 3 144 1", n, Result, ovf);
        end
        step(); step();
        checks++;
        if (Result !== 8'd144 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold Result=%0d ovf=%b want 144 1", Result, ovf);
        end
    endtask

    task automatic test_zero_count();
        int n;
        req1 = 1; X1 = 8'd9; Y1 = 4'd0;
        step();
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_grant gnt1=%b want 1", gnt1);
        end
        req1 = 0;
        wait_done(n);
        checks++;
        if (n !== 1 || Result !== 8'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL zero_op n=%0d Result=%0d ovf=%b want 1 0 0", n, Result, ovf);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit seen_done;
        req0 = 1; X0 = 8'd7; Y0 = 4'd10;
        step();
        step();
        req0 = 0;
        step(); step();
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, busy, done, ovf, Result} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset got=%b want=0", {gnt0, gnt1, busy, done, ovf, Result});
        end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) seen_done = 1;
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) seen_done = 1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done seen=%b want 0", seen_done);
        end
        req0 = 1; X0 = 8'd7; Y0 = 4'd2;
        req1 = 1; X1 = 8'd1; Y1 = 4'd1;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_grant gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        step();
        req0 = 0; req1 = 0;
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        checks++;
        if (n !== 3 || Result !== 8'd14) begin
            failures++;
            $display("FAIL post_reset_op n=%0d Result=%0d want 3 14", n, Result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_reset();
        req0 = 1; X0 = 8'd11; Y0 = 4'd1;
        req1 = 1; X1 = 8'd22; Y1 = 4'd1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(gnt0 | gnt1) && n < 10) begin step(); n++; end
            checks++;
            if (gnt0 !== (g % 2 == 0) || gnt1 !== (g % 2 == 1)) begin
                failures++;
                $display("FAIL alt_grant_%0d gnt0=%b gnt1=%b", g, gnt0, gnt1);
            end
            wait_done(n);
            checks++;
            if (n !== 2 || Result !== ((g % 2 == 0) ? 8'd11 : 8'd22)) begin
                failures++;
                $display("FAIL alt_result_%0d n=%0d Result=%0d", g, n, Result);
            end
            step();
        end
        req0 = 0; req1 = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_overflow();
        test_zero_count();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
